adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one 64-bit carry-select adder (CSA_64bit) between two requesters.
- Each requester issues an add or subtract over a valid/ready handshake.
- The block arbitrates round-robin, latches the operands and waits a programmable settle time for the adder. It then returns the registered result, tagged with the requester ID, on a single response port with backpressure.
- Sits between the lab datapath clients and the shared adder; one operation is in flight at a time.

Parameters:
- CALC_CYCLES, 2, clock cycles allowed for the adder to settle before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  64  requester 0 operand A
- req0_b  input  64  requester 0 operand B
- req0_sub  input  1  requester 0: 1 = A-B, 0 = A+B
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester that issued the result
- rsp_sum  output  64  result
- rsp_cout  output  1  adder carry out; for subtract, 1 = no borrow
- rsp_ovf  output  1  signed overflow
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, last_grant = 1 (so requester 0 wins the first tie), cnt = 0, and all result registers = 0.
  - This gives rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0, busy = 0.
  - req0_ready and req1_ready are 0 while in reset.
- FSM states: IDLE, CALC, RESP.
- IDLE, ready logic (combinational):
  - req0_ready = IDLE & req0_valid & (!req1_valid | last_grant==1).
  - req1_ready = IDLE & req1_valid & (!req0_valid | last_grant==0).
  - At most one ready is high in any cycle.
- IDLE, on a handshake (valid & ready at an edge):
  - Latch op_a = a, op_b = sub ? ~b : b, op_cin = sub, and op_id.
  - Set last_grant = op_id and load cnt = CALC_CYCLES-1.
  - Go to CALC.
- CALC, each edge:
  - cnt != 0: decrement cnt.
  - cnt == 0: capture the adder outputs (a=op_a, b=op_b, c_in=op_cin) into rsp_sum and rsp_cout. Capture rsp_ovf = (op_a[63]==op_b[63]) & (sum[63]!=op_a[63]) and rsp_id = op_id. Go to RESP.
- RESP:
  - rsp_valid = 1, and all rsp_* outputs are held stable.
  - When rsp_ready is high at an edge, go to IDLE.
  - No new request is accepted in RESP.
- Latency and throughput:
  - Handshake at edge E0 → rsp_valid is high after edge E0+CALC_CYCLES.
  - Minimum spacing between accepts is CALC_CYCLES+2 cycles, given immediate rsp_ready.
- Requester rules:
  - A requester holds valid and operands stable until it sees ready.
  - Operands may change freely after acceptance because they are latched.
- Simultaneous valids: the requester not granted last wins. A lone valid is always granted, regardless of last_grant.
- Backpressure: with rsp_ready low, the block stays in RESP indefinitely with outputs frozen, and both req*_ready stay 0.
- Reset mid-operation: the in-flight operation is discarded with no response. Reset values apply immediately (asynchronously).
- Arithmetic: the result is modulo 2^64 and there is no saturation. The subtract path is the two's complement identity A + ~B + 1.

Decomposition:
- Shared package:
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, RESP=2'd2
  - DATA_W = 64
  - requester ID constants: REQ0 = 1'b0, REQ1 = 1'b1
- Sub-module: one instance of CSA_64bit as the shared datapath. Arbitration, FSM and result registers stay in adder_arbiter.

Test Plan:
- Reset mid-operation: assert rst_n=0 during CALC → rsp_valid stays 0, busy=0 and last_grant=1. The next request is then served normally.
- Single add: req0 with a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0 → req0_ready for 1 cycle. Two cycles later: rsp_valid=1, rsp_sum=0, rsp_cout=1, rsp_ovf=0, rsp_id=0.
- Subtract: req1 with a=5, b=7, sub=1 → rsp_sum=64'hFFFF_FFFF_FFFF_FFFE, rsp_cout=0, rsp_ovf=0, rsp_id=1.
- Contention: both valid continuously for three operations with rsp_ready=1 → grants and rsp_id sequence 0,1,0; readies never high together.
- Backpressure and overflow: req0 with a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add, with rsp_ready=0 for 5 cycles. Required: rsp_sum=64'h8000_0000_0000_0000 and rsp_ovf=1, held stable; busy=1; req1_valid high but req1_ready=0 throughout. Then rsp_ready=1 → IDLE, and req1 is accepted on the following cycle.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared constants and types for the shared-adder arbiter
//
// Contents:
//   DATA_W           operand / result width
//   IDLE/CALC/RESP   FSM state encodings
//   REQ0/REQ1        requester ID values carried on rsp_id
//   op_t             latched operation (operands, carry-in, requester ID)
//   signed_ovf()     two's complement overflow from the three sign bits

package adder_arbiter_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // op_b already holds ~B for a subtract, so the adder only ever adds.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              id;
  } op_t;

  // Overflow happens only when both addends share a sign and the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/CSA_64bit.sv
// rtl/CSA_64bit.sv - 64-bit carry-select adder shared by both requesters
//
// Ports:
//   a, b    input  64  addends
//   c_in    input  1   carry into bit 0
//   sum     output 64  a + b + c_in modulo 2^64
//   c_out   output 1   carry out of bit 63

module CSA_64bit
  import adder_arbiter_pkg::*;
#(
  parameter int GROUP_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] sum,
  output logic              c_out
);

  localparam int NGRP = DATA_W / GROUP_W;

  // carry[g] is the carry into group g; each group precomputes both
  // outcomes and the incoming carry only drives a mux.
  logic [NGRP:0] carry;

  assign carry[0] = c_in;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    logic [GROUP_W:0] s0;
    logic [GROUP_W:0] s1;

    assign s0 = {1'b0, a[g*GROUP_W +: GROUP_W]} + {1'b0, b[g*GROUP_W +: GROUP_W]};
    assign s1 = {1'b0, a[g*GROUP_W +: GROUP_W]} + {1'b0, b[g*GROUP_W +: GROUP_W]}
              + {{GROUP_W{1'b0}}, 1'b1};

    assign sum[g*GROUP_W +: GROUP_W] = carry[g] ? s1[GROUP_W-1:0] : s0[GROUP_W-1:0];
    assign carry[g+1]                = carry[g] ? s1[GROUP_W]     : s0[GROUP_W];
  end

  assign c_out = carry[NGRP];

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one 64-bit adder between two requesters
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req0_valid/ready/a/b/sub      requester 0 operation handshake (sub=1: a-b)
//   req1_valid/ready/a/b/sub      requester 1 operation handshake
//   rsp_valid/ready               result handshake with backpressure
//   rsp_id                        requester that issued the result
//   rsp_sum/cout/ovf              result, carry out (no-borrow on subtract), signed overflow
//   busy                          an operation is in flight or awaiting rsp_ready

module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int CALC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              busy
);

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

  logic [1:0] state;
  logic       last_grant;
  logic [3:0] cnt;
  op_t        op_q;

  logic              accept;
  logic              acc_id;
  logic              acc_sub;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;

  // Ready is gated by rst_n so neither requester sees a handshake while
  // reset is asserted, even though state already reads IDLE.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && req0_valid &&
                 (!req1_valid || (last_grant == REQ1));
    req1_ready = rst_n && (state == IDLE) && req1_valid &&
                 (!req0_valid || (last_grant == REQ0));
  end

  assign accept  = req0_ready || req1_ready;
  assign acc_id  = req1_ready ? REQ1 : REQ0;
  assign acc_a   = req1_ready ? req1_a   : req0_a;
  assign acc_b   = req1_ready ? req1_b   : req0_b;
  assign acc_sub = req1_ready ? req1_sub : req0_sub;

  CSA_64bit u_csa (
    .a     (op_q.a),
    .b     (op_q.b),
    .c_in  (op_q.cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ1;
      cnt        <= 4'd0;
      op_q       <= '0;
      rsp_id     <= REQ0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtract is folded into an add: A + ~B + 1.
            op_q.a     <= acc_a;
            op_q.b     <= acc_sub ? ~acc_b : acc_b;
            op_q.cin   <= acc_sub;
            op_q.id    <= acc_id;
            last_grant <= acc_id;
            cnt        <= CNT_LOAD;
            state      <= CALC;
          end
        end
        CALC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_sum  <= add_sum;
            rsp_cout <= add_cout;
            rsp_ovf  <= signed_ovf(op_q.a[DATA_W-1], op_q.b[DATA_W-1], add_sum[DATA_W-1]);
            rsp_id   <= op_q.id;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter

module tb_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [63:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
  logic [63:0] rsp_sum;

  typedef struct {
    bit          id;
    logic [63:0] sum;
    bit          cout;
    bit          ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  adder_arbiter #(.CALC_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic; borrow-free compare for cout on subtract.
  function automatic exp_t model(input bit id, input logic [63:0] a, input logic [63:0] b, input bit sub);
    exp_t        e;
    logic [64:0] w;
    e.id = id;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[63] != b[63]) && (e.sum[63] != a[63]);
    end else begin
      w      = {1'b0, a} + {1'b0, b};
      e.sum  = w[63:0];
      e.cout = w[64];
      e.ovf  = (a[63] == b[63]) && (e.sum[63] != a[63]);
    end
    return e;
  endfunction

  // Response monitor: every accepted response is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got id=%0d sum=%h, expected no response", rsp_id, rsp_sum);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {e.id, e.sum, e.cout, e.ovf}) begin
          n_err++;
          $display("FAIL rsp_data: got id=%0d sum=%h cout=%0d ovf=%0d, expected id=%0d sum=%h cout=%0d ovf=%0d",
                   rsp_id, rsp_sum, rsp_cout, rsp_ovf, e.id, e.sum, e.cout, e.ovf);
        end
      end
    end
    if (rst_n && req0_valid && req1_valid) begin
      n_cmp++;
      if (req0_ready && req1_ready) begin
        n_err++;
        $display("FAIL ready_exclusive: got req0_ready=1 req1_ready=1, expected at most one");
      end
    end
  end

  task automatic issue(input bit id, input logic [63:0] a, input logic [63:0] b, input bit sub);
    bit got;
    got = 0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) got = 1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL issue_timeout: got no ready for req%0d, expected ready", id);
    end else begin
      sb.push_back(model(id, a, b, sub));
    end
    @(negedge clk);
    // Operands are scrambled after acceptance to show they were latched.
    if (id) begin
      req1_valid = 0; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_sub = ~sub;
    end else begin
      req0_valid = 0; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_sub = ~sub;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    req0_valid = 1; req0_a = 64'd1; req0_b = 64'd2; req0_sub = 0;
    req1_valid = 1; req1_a = 64'd3; req1_b = 64'd4; req1_sub = 0;
    rsp_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy, req0_ready, req1_ready} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_values: got valid=%0d id=%0d sum=%h cout=%0d ovf=%0d busy=%0d r0=%0d r1=%0d, expected all 0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy, req0_ready, req1_ready);
    end
    req0_valid = 0;
    req1_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_add();
    rsp_ready = 1;
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    #1;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL add_lat_e0: got valid=%0d busy=%0d, expected valid=0 busy=1", rsp_valid, busy);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_lat_e1: got valid=%0d, expected 0", rsp_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_lat_e2: got valid=%0d id=%0d sum=%h cout=%0d ovf=%0d, expected valid=1 id=0 sum=0 cout=1 ovf=0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf);
    end
    wait_drain();
  endtask

  task automatic test_sub();
    bit seen;
    seen = 0;
    rsp_ready = 1;
    issue(1, 64'd5, 64'd7, 1);
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (rsp_valid) seen = 1;
      else @(negedge clk);
    end
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_result: got valid=%0d id=%0d sum=%h cout=%0d ovf=%0d, expected valid=1 id=1 sum=fffffffffffffffe cout=0 ovf=0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf);
    end
    wait_drain();
  endtask

  task automatic test_contention();
    int grants;
    int seq[3];
    int exp_seq[3];
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0;
    seq[0] = -1; seq[1] = -1; seq[2] = -1;
    grants = 0;
    rsp_ready = 1;
    @(negedge clk);
    req0_valid = 1; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_sub = 0;
    req1_valid = 1; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_sub = 1;
    for (int i = 0; i < 200 && grants < 3; i++) begin
      #1;
      if (req0_ready) begin
        sb.push_back(model(0, req0_a, req0_b, req0_sub));
        seq[grants] = 0;
        grants++;
        @(negedge clk);
        req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_sub = ~req0_sub;
      end else if (req1_ready) begin
        sb.push_back(model(1, req1_a, req1_b, req1_sub));
        seq[grants] = 1;
        grants++;
        @(negedge clk);
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_sub = ~req1_sub;
      end else begin
        @(negedge clk);
      end
    end
    req0_valid = 0;
    req1_valid = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (seq[k] != exp_seq[k]) begin
        n_err++;
        $display("FAIL contention_grant%0d: got %0d, expected %0d", k, seq[k], exp_seq[k]);
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 0;
    rsp_ready = 0;
    issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    req1_valid = 1; req1_a = 64'd100; req1_b = 64'd58; req1_sub = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (rsp_valid) seen = 1;
      else @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({rsp_valid, rsp_sum, rsp_ovf, busy, req1_ready} !== {1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure_hold%0d: got valid=%0d sum=%h ovf=%0d busy=%0d r1=%0d, expected valid=1 sum=8000000000000000 ovf=1 busy=1 r1=0",
                 k, rsp_valid, rsp_sum, rsp_ovf, busy, req1_ready);
      end
      @(negedge clk); #1;
    end
    rsp_ready = 1;
    @(negedge clk); #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: got req1_ready=%0d, expected 1", req1_ready);
    end else begin
      sb.push_back(model(1, req1_a, req1_b, req1_sub));
    end
    @(negedge clk);
    req1_valid = 0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1;
    issue(1, 64'h1234, 64'h10, 0);
    rst_n = 0;
    req0_valid = 1; req0_a = 64'h0F0F_0000_0000_0001; req0_b = 64'h0101_0000_0000_0002; req0_sub = 1;
    #1;
    n_cmp++;
    if ({rsp_valid, busy, req0_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%0d busy=%0d r0=%0d, expected all 0", rsp_valid, busy, req0_ready);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    req1_valid = 1; req1_a = 64'd9; req1_b = 64'd9; req1_sub = 0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_mid_grant: got r0=%0d r1=%0d, expected r0=1 r1=0", req0_ready, req1_ready);
    end else begin
      sb.push_back(model(0, req0_a, req0_b, req0_sub));
    end
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    wait_drain();
  endtask

  task automatic test_patterns();
    bit          t_id[6];
    logic [63:0] t_a[6];
    logic [63:0] t_b[6];
    bit          t_sub[6];
    t_id[0] = 0; t_a[0] = 64'd0;                  t_b[0] = 64'd0;                  t_sub[0] = 1;
    t_id[1] = 1; t_a[1] = 64'h8000_0000_0000_0000; t_b[1] = 64'd1;                  t_sub[1] = 1;
    t_id[2] = 0; t_a[2] = 64'h8000_0000_0000_0000; t_b[2] = 64'h8000_0000_0000_0000; t_sub[2] = 0;
    t_id[3] = 1; t_a[3] = 64'hDEAD_BEEF_0000_FFFF; t_b[3] = 64'h1234_5678_9ABC_DEF0; t_sub[3] = 0;
    t_id[4] = 0; t_a[4] = 64'd3;                  t_b[4] = 64'hFFFF_FFFF_FFFF_FFFF; t_sub[4] = 1;
    t_id[5] = 1; t_a[5] = {$urandom, $urandom};   t_b[5] = {$urandom, $urandom};   t_sub[5] = 1;
    rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      issue(t_id[k], t_a[k], t_b[k], t_sub[k]);
      wait_drain();
    end
  endtask

  initial begin
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_sub = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_sub = 0;
    rsp_ready = 0;
    rst_n = 0;
    test_reset();
    test_single_add();
    test_sub();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_patterns();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
